// File: rtl/byte_serial_tx.sv
// Byte-serial transmitter: start bit, 8 data bits, optional even parity, stop bit.
// Define BYTE_SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module byte_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          MSB_FIRST    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned      DIV_W    = $clog2(CLKS_PER_BIT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef BYTE_SERIAL_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;
`ifdef BYTE_SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign bit_end = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: every _d gets its hold value first so no branch can infer a latch.
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
`ifdef BYTE_SERIAL_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (din_valid) begin
               state_d   = S_START;
               shift_d   = din;
               div_d     = '0;
               bit_cnt_d = '0;
`ifdef BYTE_SERIAL_TX_PARITY_EN
               parity_d  = ^din;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               div_d = '0;
               if (bit_cnt_q == 3'd7) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`ifdef BYTE_SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they land in registers aligned with it.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (div_d == DIV_LAST);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = MSB_FIRST ? shift_d[7] : shift_d[0];
`ifdef BYTE_SERIAL_TX_PARITY_EN
         S_PARITY: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking only, so every flop updates from the values present before the edge.
      if (reset) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef BYTE_SERIAL_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef BYTE_SERIAL_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign din_ready = (state_q == S_IDLE);
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Bench for byte_serial_tx: two configurations (4 clk/bit LSB-first, 1 clk/bit MSB-first)
// checked every cycle against a frame-level model, plus table-driven and corner-case frames.
module tb_byte_serial_tx;

   localparam int CPB_A = 4;
   localparam int CPB_B = 1;
`ifdef BYTE_SERIAL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din_a = '0, din_b = '0;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   byte_serial_tx #(.CLKS_PER_BIT(CPB_A), .MSB_FIRST(1'b0)) dut_a (
      .clk(clk), .reset(reset), .din(din_a), .din_valid(valid_a),
      .din_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

   byte_serial_tx #(.CLKS_PER_BIT(CPB_B), .MSB_FIRST(1'b1)) dut_b (
      .clk(clk), .reset(reset), .din(din_b), .din_valid(valid_b),
      .din_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

   typedef struct packed {
      logic [7:0] din;
      logic [7:0] seq_lsb;   // data bits in send order, first-sent in bit 7
      logic [7:0] seq_msb;
      logic       par;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int cpb(input int d);
      return (d == 0) ? CPB_A : CPB_B;
   endfunction
   function automatic logic [3:0] outs(input int d);
      return (d == 0) ? {tx_a, busy_a, done_a, ready_a} : {tx_b, busy_b, done_b, ready_b};
   endfunction
   function automatic logic get_tx(input int d);    return (d == 0) ? tx_a : tx_b;       endfunction
   function automatic logic get_done(input int d);  return (d == 0) ? done_a : done_b;   endfunction
   function automatic logic get_ready(input int d); return (d == 0) ? ready_a : ready_b; endfunction
   function automatic logic get_valid(input int d); return (d == 0) ? valid_a : valid_b; endfunction
   function automatic logic [7:0] get_din(input int d); return (d == 0) ? din_a : din_b; endfunction

   task automatic drive(input int d, input logic v, input logic [7:0] x);
      if (d == 0) begin valid_a = v; din_a = x; end
      else        begin valid_b = v; din_b = x; end
   endtask

   // Slot i of the frame stored at bit i; the last slot is always the stop bit.
   function automatic logic [10:0] exp_frame(input logic [7:0] seq, input logic par);
      logic [10:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = seq[7-i];
      f[9]    = par;
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // Frame-level reference: on accept, expand the bit list into a per-cycle tx waveform.
   logic m_bits [2][48];
   int   m_len  [2];
   int   m_pos  [2];
   bit   m_act  [2];

   task automatic model_accept(input int d, input logic [7:0] x);
      logic slot [11];
      slot[0] = 1'b0;
      for (int i = 0; i < 8; i++) slot[1+i] = (d == 1) ? x[7-i] : x[i];
      slot[9]    = ^x;
      slot[10]   = 1'b1;
      slot[NB-1] = 1'b1;
      for (int s = 0; s < NB; s++)
         for (int r = 0; r < cpb(d); r++) m_bits[d][s*cpb(d)+r] = slot[s];
      m_len[d] = NB * cpb(d);
      m_pos[d] = 0;
      m_act[d] = 1'b1;
   endtask

   function automatic logic [3:0] exp_outs(input int d);
      if (!m_act[d]) return 4'b1001;
      return {m_bits[d][m_pos[d]], 1'b1, (m_pos[d] == m_len[d] - 1), 1'b0};
   endfunction

   initial forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (reset) m_act[d] = 1'b0;
         else if (m_act[d]) begin
            m_pos[d]++;
            if (m_pos[d] == m_len[d]) m_act[d] = 1'b0;
         end else if (get_valid(d)) model_accept(d, get_din(d));
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_on)
         for (int d = 0; d < 2; d++) check($sformatf("model_%0d", d), outs(d), exp_outs(d));
   end

   task automatic wait_ready(input int d);
      int t = 0;
      while (!get_ready(d) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!get_ready(d)) check("ready_timeout", get_ready(d), 1);
   endtask

   // Starts at the negedge before the accept edge; ends at the negedge of the frame's last cycle.
   task automatic capture_frame(input int d, input bit hold, input int chg_k, input logic [7:0] chg_v,
                                output logic [10:0] bits, output int done_k);
      int c;
      c = cpb(d);
      bits = '0;
      done_k = -1;
      for (int k = 1; k <= NB * c; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) drive(d, 1'b0, get_din(d));
         if (k == chg_k) drive(d, get_valid(d), chg_v);
         if ((k - 1) % c == 0) bits[(k-1)/c] = get_tx(d);
         if (get_done(d) && done_k < 0) done_k = k;
      end
   endtask

   task automatic send_vec(input int d, input vec_t v, input int chg_k, input logic [7:0] chg_v);
      logic [10:0] bits;
      int          dk;
      wait_ready(d);
      drive(d, 1'b1, v.din);
      capture_frame(d, 1'b0, chg_k, chg_v, bits, dk);
      check($sformatf("frame_%0d_%0h", d, v.din), bits,
            exp_frame((d == 0) ? v.seq_lsb : v.seq_msb, v.par));
      check($sformatf("done_at_%0d_%0h", d, v.din), dk, NB * cpb(d));
      @(negedge clk);
      check($sformatf("gap_%0d_%0h", d, v.din), outs(d), 4'b1001);
   endtask

   initial begin
      logic [10:0] bits;
      int          dk;

      vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
      vecs[1] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0};
      vecs[2] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
      vecs[3] = '{8'hC3, 8'b11000011, 8'b11000011, 1'b0};
      vecs[4] = '{8'h07, 8'b11100000, 8'b00000111, 1'b1};
      vecs[5] = '{8'h03, 8'b11000000, 8'b00000011, 1'b0};
      vecs[6] = '{8'h12, 8'b01001000, 8'b00010010, 1'b0};
      vecs[7] = '{8'h6B, 8'b11010110, 8'b01101011, 1'b1};
      vecs[8] = '{8'h55, 8'b10101010, 8'b01010101, 1'b0};

      // Reset for three edges, then idle with din_valid low.
      repeat (3) @(posedge clk);
      model_on = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_a", outs(0), 4'b1001);
         check("idle_b", outs(1), 4'b1001);
      end

      for (int i = 0; i < 9; i++)
         for (int d = 0; d < 2; d++) send_vec(d, vecs[i], 0, 8'h00);

      // din moves to 0xFF mid-frame after accept; the frame must still carry 0x12.
      send_vec(0, vecs[6], 10, 8'hFF);

      // Held valid: 0x3C then 0xC3 with exactly one idle-high cycle between them.
      wait_ready(0);
      drive(0, 1'b1, 8'h3C);
      capture_frame(0, 1'b1, 20, 8'hC3, bits, dk);
      check("b2b_frame1", bits, exp_frame(8'b00111100, 1'b0));
      @(negedge clk);
      check("b2b_gap", outs(0), 4'b1001);
      capture_frame(0, 1'b0, 0, 8'h00, bits, dk);
      check("b2b_frame2", bits, exp_frame(8'b11000011, 1'b0));
      check("b2b_done2", dk, NB * CPB_A);

      // Reset lands during data bit 3 of 0x00.
      wait_ready(0);
      drive(0, 1'b1, 8'h00);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) drive(0, 1'b0, 8'h00);
      end
      check("pre_reset", outs(0), 4'b0100);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid", outs(0), 4'b1001);
      reset = 1'b0;
      send_vec(0, vecs[8], 0, 8'h00);

      // Random traffic with occasional resets; the per-cycle model does the checking.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         drive(0, $urandom_range(0, 3) != 0, 8'($urandom));
         drive(1, $urandom_range(0, 3) != 0, 8'($urandom));
      end
      reset = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      repeat (60) @(negedge clk);
      check("final_idle_a", outs(0), 4'b1001);
      check("final_idle_b", outs(1), 4'b1001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
